// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// FetchQueue (module fetch_queue)
//
// Decode-side receiver for the fetch stage's {pc, pcplus4, instr} stream.
// It replaces a plain IF/ID register with a small circular FIFO of DEPTH
// entries. The oldest entry is presented show-ahead to decode. When the queue
// is full, stall is raised back to fetch. A branch redirect (flush) throws
// away every buffered wrong-path entry.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   XLEN       width of pc, pcplus4 and instr
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      redirect from execute; empties the queue
//   in_valid   fetch presents a real instruction this cycle
//   in_pc      fetch pc
//   in_pcplus4 fetch pc+4
//   in_instr   fetched instruction word
//   stall      queue full, fetch must hold its pc
//   d_valid    head entry valid for decode
//   d_ready    decode accepts the head entry this cycle
//   d_pc       head pc (0 when d_valid=0)
//   d_pcplus4  head pc+4 (0 when d_valid=0)
//   d_instr    head instruction (NOP 32'h00000013 when d_valid=0)
//   count      current occupancy, 0..DEPTH
//
// Optional feature:
//   FETCH_QUEUE_BYPASS_EN  when defined, an empty queue forwards the fetch
//                          inputs straight to decode in the same cycle.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pcplus4,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     stall,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_pcplus4,
  output logic [XLEN-1:0]          d_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;

  logic [XLEN-1:0] mem_pc      [DEPTH];
  logic [XLEN-1:0] mem_pcplus4 [DEPTH];
  logic [XLEN-1:0] mem_instr   [DEPTH];

  logic            enq;
  logic            deq;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_pcplus4;
  logic [XLEN-1:0] head_instr;

  // Full is decoded from the registered occupancy only, so stall never
  // depends combinationally on d_ready or in_valid.
  assign stall = (occ == CW'(DEPTH));
  assign count = occ;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue hands the incoming entry straight to decode; if decode
  // takes it this cycle it never needs to be written.
  logic byp_take;
  assign byp_take = (occ == '0) & ~flush & in_valid & d_ready;
  assign enq      = in_valid & ~stall & ~flush & ~byp_take;
`else
  assign enq      = in_valid & ~stall & ~flush;
`endif
  assign deq      = (occ != '0) & d_ready & ~flush;

  // Head selection: normally the storage entry at rd_ptr; with bypass the
  // fetch inputs when the queue is empty. Payload is zeroed (instr forced to
  // NOP) whenever nothing valid is being presented.
  always_comb begin
    head_valid   = (occ != '0);
    head_pc      = mem_pc[rd_ptr];
    head_pcplus4 = mem_pcplus4[rd_ptr];
    head_instr   = mem_instr[rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (flush) begin
      head_valid = 1'b0;
    end else if (occ == '0) begin
      head_valid   = in_valid;
      head_pc      = in_pc;
      head_pcplus4 = in_pcplus4;
      head_instr   = in_instr;
    end
`endif
    d_valid   = head_valid;
    d_pc      = head_valid ? head_pc      : '0;
    d_pcplus4 = head_valid ? head_pcplus4 : '0;
    d_instr   = head_valid ? head_instr   : NOP;
  end

  // Pointer and occupancy state. Reset beats flush, flush beats traffic.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + CW'(enq) - CW'(deq);
    end
  end

  // Storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]      <= in_pc;
      mem_pcplus4[wr_ptr] <= in_pcplus4;
      mem_instr[wr_ptr]   <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_pcplus4;
  logic [31:0] in_instr;
  logic        stall;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pcplus4;
  logic [31:0] d_instr;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_instr(in_instr),
    .stall(stall), .d_valid(d_valid), .d_ready(d_ready),
    .d_pc(d_pc), .d_pcplus4(d_pcplus4), .d_instr(d_instr), .count(count)
  );

  always #5 clk = ~clk;

  // Drive the fetch side: pcplus4 and instr derived from pc so payload can be checked.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid   = v;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
    in_instr   = pc + 32'h1000_0000;
    d_ready    = rdy;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (count !== 3'd0)  begin fails++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    tests++; if (stall !== 1'b0)  begin fails++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    tests++; if (d_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_dvalid got %b want 0", d_valid); end
    tests++; if (d_instr !== 32'h13) begin fails++; $display("[TB] FAIL reset_dinstr got %h want 00000013", d_instr); end
    tests++; if (d_pc !== 32'h0 || d_pcplus4 !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_dpc got %h/%h want 0/0", d_pc, d_pcplus4);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
      tests++; if (d_valid !== 1'b1 || d_pc !== 32'(4 * i)) begin
        fails++; $display("[TB] FAIL stream_bypass i=%0d got v=%b pc=%h want v=1 pc=%h", i, d_valid, d_pc, 4 * i);
      end
      cycle();
      tests++; if (count !== 3'd0 || stall !== 1'b0) begin
        fails++; $display("[TB] FAIL stream_count i=%0d got cnt=%0d stall=%b want 0/0", i, count, stall);
      end
`else
      cycle();
      tests++; if (d_valid !== 1'b1 || d_pc !== 32'(4 * i) || d_instr !== 32'(32'h1000_0000 + 4 * i)
                   || d_pcplus4 !== 32'(4 * i + 4)) begin
        fails++; $display("[TB] FAIL stream_head i=%0d got v=%b pc=%h instr=%h want pc=%h", i, d_valid, d_pc, d_instr, 4 * i);
      end
      tests++; if (count !== 3'd1 || stall !== 1'b0) begin
        fails++; $display("[TB] FAIL stream_count i=%0d got cnt=%0d stall=%b want 1/0", i, count, stall);
      end
`endif
    end
    drive(1'b0, 32'h0, 1'b1);
    cycle();
    tests++; if (count !== 3'd0 || d_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL stream_drain got cnt=%0d v=%b want 0/0", count, d_valid);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc [5];
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
      cycle();
    end
    tests++; if (count !== 3'd4 || stall !== 1'b1) begin
      fails++; $display("[TB] FAIL fill_full got cnt=%0d stall=%b want 4/1", count, stall);
    end
    drive(1'b1, 32'h110, 1'b0);
    cycle();
    tests++; if (count !== 3'd4 || d_pc !== 32'h100) begin
      fails++; $display("[TB] FAIL fill_hold got cnt=%0d pc=%h want 4/100", count, d_pc);
    end
    for (int i = 0; i < 5; i++) exp_pc[i] = 32'h100 + 32'(4 * i);
    k = 0;
    d_ready = 1'b1;
    #1;
    for (int c = 0; c < 12 && k < 5; c++) begin
      logic accepted;
      accepted = in_valid && !stall;
      if (d_valid && d_ready) begin
        tests++; if (d_pc !== exp_pc[k]) begin
          fails++; $display("[TB] FAIL fill_order k=%0d got %h want %h", k, d_pc, exp_pc[k]);
        end
        k++;
      end
      cycle();
      if (c == 0) begin
        tests++; if (count !== 3'd3 || stall !== 1'b0) begin
          fails++; $display("[TB] FAIL fill_unstall got cnt=%0d stall=%b want 3/0", count, stall);
        end
      end
      if (accepted) drive(1'b0, 32'h0, 1'b1);
    end
    tests++; if (k !== 5) begin fails++; $display("[TB] FAIL fill_drained got %0d want 5", k); end
    tests++; if (d_valid !== 1'b0 || count !== 3'd0) begin
      fails++; $display("[TB] FAIL fill_empty got v=%b cnt=%0d want 0/0", d_valid, count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0);
      cycle();
    end
    tests++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL flush_pre got %0d want 3", count); end
    flush = 1'b1;
    drive(1'b1, 32'h20C, 1'b1);
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests++; if (count !== 3'd0 || d_valid !== 1'b0 || d_instr !== 32'h13) begin
      fails++; $display("[TB] FAIL flush_empty got cnt=%0d v=%b instr=%h want 0/0/00000013", count, d_valid, d_instr);
    end
    drive(1'b1, 32'h400, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0);
    tests++; if (d_valid !== 1'b1 || d_pc !== 32'h400 || count !== 3'd1) begin
      fails++; $display("[TB] FAIL flush_refill got v=%b pc=%h cnt=%0d want 1/400/1", d_valid, d_pc, count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0);
      cycle();
    end
    tests++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL flush_full_pre got %b want 1", stall); end
    flush = 1'b1;
    drive(1'b1, 32'h600, 1'b1);
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests++; if (stall !== 1'b0 || count !== 3'd0) begin
      fails++; $display("[TB] FAIL flush_full got stall=%b cnt=%0d want 0/0", stall, count);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int rcv;
    do_reset();
    sent = 0;
    rcv = 0;
    for (int c = 0; c < 60 && rcv < 10; c++) begin
      drive(sent < 10, 32'h300 + 32'(4 * sent), ((c / 2) % 2) == 1);
      if (d_valid && d_ready) begin
        tests++; if (d_pc !== 32'h300 + 32'(4 * rcv)) begin
          fails++; $display("[TB] FAIL wrap_order n=%0d got %h want %h", rcv, d_pc, 32'h300 + 32'(4 * rcv));
        end
        rcv++;
      end
      if (in_valid && !stall) sent++;
      cycle();
      tests++; if (count > 3'd4) begin fails++; $display("[TB] FAIL wrap_count got %0d want <=4", count); end
    end
    drive(1'b0, 32'h0, 1'b0);
    tests++; if (rcv !== 10 || sent !== 10) begin
      fails++; $display("[TB] FAIL wrap_total got sent=%0d rcv=%0d want 10/10", sent, rcv);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(4 * i), 1'b0);
      cycle();
    end
    tests++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL rstmid_pre got %0d want 3", count); end
    rst = 1'b1;
    drive(1'b1, 32'h70C, 1'b1);
    cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tests++; if (count !== 3'd0 || stall !== 1'b0 || d_valid !== 1'b0 || d_pc !== 32'h0) begin
      fails++; $display("[TB] FAIL rstmid got cnt=%0d stall=%b v=%b pc=%h want 0/0/0/0", count, stall, d_valid, d_pc);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1'b1, 32'h80, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    tests++; if (d_valid !== 1'b1 || d_pc !== 32'h80) begin
      fails++; $display("[TB] FAIL bypass_same got v=%b pc=%h want 1/80", d_valid, d_pc);
    end
    cycle();
    drive(1'b0, 32'h0, 1'b1);
    tests++; if (count !== 3'd0 || d_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL bypass_count got cnt=%0d v=%b want 0/0", count, d_valid);
    end
`else
    tests++; if (d_valid !== 1'b0) begin fails++; $display("[TB] FAIL nobypass_same got v=%b want 0", d_valid); end
    cycle();
    drive(1'b0, 32'h0, 1'b1);
    tests++; if (d_valid !== 1'b1 || d_pc !== 32'h80 || count !== 3'd1) begin
      fails++; $display("[TB] FAIL nobypass_next got v=%b pc=%h cnt=%0d want 1/80/1", d_valid, d_pc, count);
    end
    cycle();
    tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL nobypass_drain got %0d want 0", count); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_pcplus4 = '0;
    in_instr = '0;
    d_ready = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
